rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: ch0 (ALU/load path) and ch1 (multi-cycle mul/div unit).
- Uses round-robin arbitration with a valid/ready handshake on each channel.
- Drives the register file write port from registered outputs.
- Holds a per-register pending-write scoreboard so the issue stage can stall on read-after-write (RAW) hazards against outstanding writes.

Parameters:
- reg_add_width, 5, register address width
- reg_width, 32, data width
- reg_depth, 32, number of registers and scoreboard bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  ch0 has a write-back pending
- req0_ready  out  1  ch0 granted this cycle
- req0_add  in  reg_add_width  ch0 destination register
- req0_data  in  reg_width  ch0 write data
- req1_valid  in  1  ch1 has a write-back pending
- req1_ready  out  1  ch1 granted this cycle
- req1_add  in  reg_add_width  ch1 destination register
- req1_data  in  reg_width  ch1 write data
- wr_en_rf  out  1  register file write enable (registered)
- wr_add_rf  out  reg_add_width  register file write address (registered)
- wrd_rf  out  reg_width  register file write data (registered)
- rsv_en  in  1  issue stage reserves a destination register
- rsv_add  in  reg_add_width  register being reserved
- rd_add_q1  in  reg_add_width  hazard query address 1
- rd_add_q2  in  reg_add_width  hazard query address 2
- busy1  out  1  write pending for rd_add_q1 (combinational)
- busy2  out  1  write pending for rd_add_q2 (combinational)
- sb_err  out  1  sticky: a register was reserved while already busy

Behaviour:
- Reset:
  - Synchronous on rst=1 at a clk edge.
  - wr_en_rf=0, wr_add_rf=0, wrd_rf=0.
  - All busy bits cleared; sb_err=0.
  - Round-robin pointer set to favour ch0.
  - A reset mid-transfer discards any granted-but-unwritten request.
- Arbitration (combinational, no gaps):
  - Only one valid: that channel is granted.
  - Both valid: the pointer's channel is granted.
  - Neither valid: no grant.
  - reqN_ready = grant for N. At most one ready is high per cycle.
  - ready never depends on the ready signal of the other channel.
- Transfer:
  - A transfer occurs on ch N when reqN_valid & reqN_ready at the clk edge.
  - After a transfer on ch N, the pointer moves to favour the other channel. With no transfer, the pointer holds.
  - Requesters hold valid, add and data stable until ready.
- Write latency: one cycle.
  - The edge that accepts a request loads wr_add_rf and wrd_rf, and sets wr_en_rf=1.
  - The register file writes on the following edge.
  - wr_en_rf drops the cycle after the last transfer.
  - Back-to-back transfers give continuous wr_en_rf=1, alternating channels when both stay valid.
- Register 0:
  - A request to address 0 is accepted with normal handshake and pointer update, but wr_en_rf stays 0 for that slot.
  - rsv_en with rsv_add=0 is ignored.
  - busyN is always 0 for query address 0.
- Scoreboard:
  - busy[a] set at the edge where rsv_en=1 and rsv_add=a.
  - busy[a] cleared at the edge where wr_en_rf=1 and wr_add_rf=a, i.e. the edge at which the register file commits the write.
  - Reserve and clear of the same address on the same edge: reserve wins, busy stays 1.
  - Reserve of an address whose busy bit is already 1 and not clearing that edge: busy stays 1 and sb_err sets. The scoreboard has no counting, so the issue stage must stall WAW.
  - sb_err clears only on rst.
- Hazard query: busyN = busy[rd_add_qN] & (rd_add_qN != 0), read from current state. While wr_en_rf=1 for address a, busy for a still reads 1 in that cycle.

Test Plan:
- Reset clears state: assert rst during active writes -> next cycle wr_en_rf=0, busy1=busy2=0, sb_err=0, and a subsequent single ch0 request is granted first.
- Single channel: req0 valid, add=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle wr_en_rf=1, wr_add_rf=5, wrd_rf=0xDEADBEEF; following cycle wr_en_rf=0.
- Contention: both valid continuously, ch0 add=3 data=0x11, ch1 add=4 data=0x22, starting from reset -> grants alternate 0,1,0,1; wr_add_rf sequence 3,4,3,4 with wr_en_rf held 1.
- Register 0: req1 add=0 data=0xFFFFFFFF -> req1_ready=1 and pointer advances; wr_en_rf stays 0.
- Scoreboard RAW: rsv_en add=7, then query rd_add_q1=7 -> busy1=1 until the edge where wr_en_rf=1 with wr_add_rf=7; busy1=0 the cycle after. Query address 0 always gives busy=0.
- Same-edge and conflict cases:
  - rsv_add=9 on the same edge as the completing write to 9 -> busy stays 1, sb_err=0.
  - A second reserve of 9 while busy -> sb_err=1, held until rst.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single register-file write port between two write-back
// requesters and keeps a per-register pending-write scoreboard for the
// issue stage.
//
//   ch0 : ALU / load write-back path
//   ch1 : multi-cycle mul/div write-back path
//
// Arbitration is round-robin with a valid/ready handshake per channel. The
// grant is combinational, so a lone requester is accepted in the same cycle
// with no bubbles. An accepted request is written to the register-file port
// registers on the accepting edge. The register file commits it on the
// following edge.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0_valid/ready/add/data      ch0 write-back handshake and payload
//   req1_valid/ready/add/data      ch1 write-back handshake and payload
//   wr_en_rf, wr_add_rf, wrd_rf    registered register-file write port
//   rsv_en, rsv_add                issue-stage destination reservation
//   rd_add_q1, rd_add_q2           hazard query addresses
//   busy1, busy2                   pending write on query address (comb.)
//   sb_err                         sticky: reserve of an already-busy register
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int reg_add_width = 5,
    parameter int reg_width     = 32,
    parameter int reg_depth     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [reg_add_width-1:0] req0_add,
    input  logic [reg_width-1:0]     req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [reg_add_width-1:0] req1_add,
    input  logic [reg_width-1:0]     req1_data,
    output logic                     wr_en_rf,
    output logic [reg_add_width-1:0] wr_add_rf,
    output logic [reg_width-1:0]     wrd_rf,
    input  logic                     rsv_en,
    input  logic [reg_add_width-1:0] rsv_add,
    input  logic [reg_add_width-1:0] rd_add_q1,
    input  logic [reg_add_width-1:0] rd_add_q2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     sb_err
);

    // Which channel wins when both are valid.
    typedef enum logic {
        FAV_CH0 = 1'b0,
        FAV_CH1 = 1'b1
    } fav_t;

    // One-hot decode of a register address. Addresses beyond reg_depth
    // decode to nothing, so a narrower scoreboard is safe.
    function automatic logic [reg_depth-1:0] addr_onehot(
        input logic [reg_add_width-1:0] a
    );
        logic [reg_depth-1:0] d;
        d = '0;
        for (int i = 0; i < reg_depth; i++) begin
            if (a == reg_add_width'(i)) begin
                d[i] = 1'b1;
            end else begin
                d[i] = 1'b0;
            end
        end
        return d;
    endfunction

    // Scoreboard bit lookup; register 0 is never reported busy.
    function automatic logic busy_lookup(
        input logic [reg_depth-1:0]     v,
        input logic [reg_add_width-1:0] a
    );
        logic r;
        r = 1'b0;
        for (int i = 1; i < reg_depth; i++) begin
            if (a == reg_add_width'(i)) begin
                r = v[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // State
    fav_t                     fav_r;
    logic                     wr_en_rf_r;
    logic [reg_add_width-1:0] wr_add_rf_r;
    logic [reg_width-1:0]     wrd_rf_r;
    logic [reg_depth-1:0]     busy_r;
    logic                     sb_err_r;

    // Next-state / combinational
    logic                     grant0_s;
    logic                     grant1_s;
    fav_t                     fav_nxt_s;
    logic                     wr_en_nxt_s;
    logic [reg_add_width-1:0] wr_add_nxt_s;
    logic [reg_width-1:0]     wrd_nxt_s;
    logic                     rsv_live_s;
    logic                     clr_same_s;
    logic [reg_depth-1:0]     clr_vec_s;
    logic [reg_depth-1:0]     set_vec_s;
    logic [reg_depth-1:0]     busy_nxt_s;
    logic                     sb_err_nxt_s;

    // Round-robin grant: a lone requester always wins; on contention the
    // favoured channel wins. Grants depend only on valids and the pointer.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b11: begin
                if (fav_r == FAV_CH0) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Write-port next state: load the winner's payload; writes to register 0
    // take the slot but keep the enable low. The pointer moves past the
    // channel that just transferred and holds otherwise.
    always_comb begin
        fav_nxt_s    = fav_r;
        wr_en_nxt_s  = 1'b0;
        wr_add_nxt_s = wr_add_rf_r;
        wrd_nxt_s    = wrd_rf_r;
        if (grant0_s) begin
            wr_en_nxt_s  = (req0_add != {reg_add_width{1'b0}});
            wr_add_nxt_s = req0_add;
            wrd_nxt_s    = req0_data;
            fav_nxt_s    = FAV_CH1;
        end else if (grant1_s) begin
            wr_en_nxt_s  = (req1_add != {reg_add_width{1'b0}});
            wr_add_nxt_s = req1_add;
            wrd_nxt_s    = req1_data;
            fav_nxt_s    = FAV_CH0;
        end else begin
            wr_en_nxt_s  = 1'b0;
        end
    end

    // Scoreboard next state. The clear uses the registered write port, i.e.
    // the edge at which the register file commits; a same-edge reserve wins
    // because set is OR-ed in after the clear.
    always_comb begin
        rsv_live_s   = rsv_en && (rsv_add != {reg_add_width{1'b0}});
        clr_same_s   = wr_en_rf_r && (wr_add_rf_r == rsv_add);
        clr_vec_s    = '0;
        set_vec_s    = '0;
        sb_err_nxt_s = sb_err_r;
        if (wr_en_rf_r) begin
            clr_vec_s = addr_onehot(wr_add_rf_r);
        end else begin
            clr_vec_s = '0;
        end
        if (rsv_live_s) begin
            set_vec_s = addr_onehot(rsv_add);
            if (busy_lookup(busy_r, rsv_add) && !clr_same_s) begin
                sb_err_nxt_s = 1'b1;
            end else begin
                sb_err_nxt_s = sb_err_r;
            end
        end else begin
            set_vec_s = '0;
        end
        busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
    end

    // State register: arbitration pointer, write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            fav_r       <= FAV_CH0;
            wr_en_rf_r  <= 1'b0;
            wr_add_rf_r <= '0;
            wrd_rf_r    <= '0;
            busy_r      <= '0;
            sb_err_r    <= 1'b0;
        end else begin
            fav_r       <= fav_nxt_s;
            wr_en_rf_r  <= wr_en_nxt_s;
            wr_add_rf_r <= wr_add_nxt_s;
            wrd_rf_r    <= wrd_nxt_s;
            busy_r      <= busy_nxt_s;
            sb_err_r    <= sb_err_nxt_s;
        end
    end

    assign wr_en_rf  = wr_en_rf_r;
    assign wr_add_rf = wr_add_rf_r;
    assign wrd_rf    = wrd_rf_r;
    assign sb_err    = sb_err_r;

    // Hazard queries read current state, so a write being committed this
    // cycle still reports busy.
    assign busy1 = busy_lookup(busy_r, rd_add_q1);
    assign busy2 = busy_lookup(busy_r, rd_add_q2);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed scenarios with literal expectations followed by randomized
// traffic. A behavioural model (favoured channel, pending-write bit array,
// sticky error, expected write-port contents) predicts every output and is
// compared on every cycle.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_add, req1_add;
    logic [DW-1:0] req0_data, req1_data;
    logic          wr_en_rf;
    logic [AW-1:0] wr_add_rf;
    logic [DW-1:0] wrd_rf;
    logic          rsv_en;
    logic [AW-1:0] rsv_add, rd_add_q1, rd_add_q2;
    logic          busy1, busy2, sb_err;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.reg_add_width(AW), .reg_width(DW), .reg_depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_add(req0_add), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_add(req1_add), .req1_data(req1_data),
        .wr_en_rf(wr_en_rf), .wr_add_rf(wr_add_rf), .wrd_rf(wrd_rf),
        .rsv_en(rsv_en), .rsv_add(rsv_add),
        .rd_add_q1(rd_add_q1), .rd_add_q2(rd_add_q2),
        .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int             fav;        // channel that wins on contention
    bit [DEPTH-1:0] busy_m;
    bit             err_m;
    bit             wen_m;
    logic [AW-1:0]  wadd_m;
    logic [DW-1:0]  wdata_m;
    bit             acc0, acc1; // requester saw its request taken last edge

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules say must be granted now (-1 = none).
    function automatic int winner();
        if (req0_valid && req1_valid) return fav;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit busy_exp(input logic [AW-1:0] a);
        return (a != 0) && busy_m[a];
    endfunction

    task automatic compare_all();
        int w;
        w = winner();
        chk("req0_ready", req0_ready, w == 0);
        chk("req1_ready", req1_ready, w == 1);
        chk("wr_en_rf",   wr_en_rf,   wen_m);
        chk("wr_add_rf",  wr_add_rf,  wadd_m);
        chk("wrd_rf",     wrd_rf,     wdata_m);
        chk("busy1",      busy1,      busy_exp(rd_add_q1));
        chk("busy2",      busy2,      busy_exp(rd_add_q2));
        chk("sb_err",     sb_err,     err_m);
    endtask

    // Apply the rules for one clock edge to the model.
    task automatic model_edge(input int w);
        bit [DEPTH-1:0] nb;
        if (rst) begin
            fav = 0; busy_m = '0; err_m = 1'b0;
            wen_m = 1'b0; wadd_m = '0; wdata_m = '0;
        end else begin
            nb = busy_m;
            if (wen_m) nb[wadd_m] = 1'b0;
            if (rsv_en && rsv_add != 0) begin
                if (busy_m[rsv_add] && !(wen_m && wadd_m == rsv_add)) err_m = 1'b1;
                nb[rsv_add] = 1'b1;
            end
            busy_m = nb;
            if (w == 0) begin
                wen_m = (req0_add != 0); wadd_m = req0_add; wdata_m = req0_data; fav = 1;
            end else if (w == 1) begin
                wen_m = (req1_add != 0); wadd_m = req1_add; wdata_m = req1_data; fav = 0;
            end else begin
                wen_m = 1'b0;
            end
        end
    endtask

    // Inputs are driven at the falling edge; let them settle and check.
    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic tick();
        int w;
        w = winner();
        acc0 = (w == 0);
        acc1 = (w == 1);
        @(posedge clk);
        model_edge(w);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_add = '0; req1_add = '0; req0_data = '0; req1_data = '0;
        rsv_en = 1'b0; rsv_add = '0; rd_add_q1 = '0; rd_add_q2 = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        fav = 0; busy_m = '0; err_m = 1'b0; wen_m = 1'b0; wadd_m = '0; wdata_m = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        settle();
        chk("reset_wr_en", wr_en_rf, 1'b0);
        chk("reset_sb_err", sb_err, 1'b0);

        // Single channel
        req0_valid = 1'b1; req0_add = 5'd5; req0_data = 32'hDEADBEEF;
        settle();
        chk("single_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("single_wr_en", wr_en_rf, 1'b1);
        chk("single_wr_add", wr_add_rf, 32'd5);
        chk("single_wrd", wrd_rf, 32'hDEADBEEF);
        tick();
        settle();
        chk("single_wr_en_drop", wr_en_rf, 1'b0);

        // Contention from reset: grants 0,1,0,1,0 and writes 3,4,3,4
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_add = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_add = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("cont_ready0", req0_ready, (i % 2) == 0);
            chk("cont_ready1", req1_ready, (i % 2) == 1);
            if (i > 0) begin
                chk("cont_wr_en", wr_en_rf, 1'b1);
                chk("cont_wr_add", wr_add_rf, ((i % 2) == 1) ? 32'd3 : 32'd4);
            end
            tick();
        end

        // Register 0 on ch1 (pointer now favours ch1)
        req0_valid = 1'b0;
        req1_add = 5'd0; req1_data = 32'hFFFFFFFF;
        settle();
        chk("r0_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        settle();
        chk("r0_wr_en", wr_en_rf, 1'b0);
        req0_valid = 1'b1; req0_add = 5'd1; req1_valid = 1'b1; req1_add = 5'd2;
        settle();
        chk("r0_ptr_adv", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        settle(); tick(); settle(); tick();

        // Scoreboard RAW on register 7
        rsv_en = 1'b1; rsv_add = 5'd7; rd_add_q1 = 5'd7; rd_add_q2 = 5'd0;
        settle();
        chk("raw_before", busy1, 1'b0);
        tick();
        rsv_en = 1'b0;
        req0_valid = 1'b1; req0_add = 5'd7; req0_data = 32'h77;
        settle();
        chk("raw_busy", busy1, 1'b1);
        chk("raw_q0", busy2, 1'b0);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("raw_commit_en", wr_en_rf, 1'b1);
        chk("raw_busy_commit", busy1, 1'b1);
        tick();
        settle();
        chk("raw_cleared", busy1, 1'b0);

        // Same-edge reserve/clear of 9, then a conflicting reserve
        rsv_en = 1'b1; rsv_add = 5'd9; rd_add_q1 = 5'd9;
        tick();
        rsv_en = 1'b0;
        req0_valid = 1'b1; req0_add = 5'd9; req0_data = 32'h99;
        settle(); tick();
        req0_valid = 1'b0;
        rsv_en = 1'b1;
        settle();
        chk("same_wr_add", wr_add_rf, 32'd9);
        tick();
        rsv_en = 1'b0;
        settle();
        chk("same_busy", busy1, 1'b1);
        chk("same_no_err", sb_err, 1'b0);
        rsv_en = 1'b1;
        tick();
        rsv_en = 1'b0;
        settle();
        chk("conflict_err", sb_err, 1'b1);
        tick(); settle(); tick(); settle();
        chk("conflict_sticky", sb_err, 1'b1);

        // Reset during active writes
        req0_valid = 1'b1; req0_add = 5'd12; req0_data = 32'hA5A5A5A5;
        req1_valid = 1'b1; req1_add = 5'd13; req1_data = 32'h5A5A5A5A;
        settle(); tick(); settle(); tick();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rd_add_q1 = 5'd9; rd_add_q2 = 5'd7;
        settle();
        chk("rst_wr_en", wr_en_rf, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_busy2", busy2, 1'b0);
        chk("rst_sb_err", sb_err, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk("rst_first_ch0", req0_ready, 1'b1);
        tick();

        // Randomized traffic; requesters hold payload until accepted
        for (int n = 0; n < 4000; n++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_add   = 5'($urandom_range(0, 15));
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 99) < 45);
                req1_add   = 5'($urandom_range(0, 15));
                req1_data  = $urandom;
            end
            rsv_en    = ($urandom_range(0, 99) < 30);
            rsv_add   = 5'($urandom_range(0, 15));
            rd_add_q1 = 5'($urandom_range(0, 15));
            rd_add_q2 = 5'($urandom_range(0, 31));
            rst       = ($urandom_range(0, 399) == 0);
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
